hilo_div: RTL and testbench

Sequential HI/LO register unit with an iterative 32-bit divider. It sits beside the combinational ALU, which has no divide. The unit captures the ALU's 64-bit multiply result into HI/LO, services MTHI/MTLO writes, and runs DIV/DIVU over multiple cycles with a busy/done handshake toward the pipeline stall logic. MFHI/MFLO read the `hi`/`lo` outputs directly.

---
 rtl/hilo_div.sv | 188 ++++++++++++++++++
 tb/tb_hilo_div.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div.sv
// rtl/hilo_div.sv - HI/LO register unit with iterative 32-bit restoring divider (option: HILO_SIGNED_DIV_EN)
module hilo_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] mul_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    localparam logic [2:0] OP_MULWB = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd2;
    localparam logic [2:0] OP_MTLO  = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd5;

`ifdef HILO_SIGNED_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_FIN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;
`endif

    state_t      state_q, state_d;
    logic [63:0] rq_q, rq_d;        // {remainder, quotient} shift register
    logic [31:0] dvs_q, dvs_d;      // divisor magnitude
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
`ifdef HILO_SIGNED_DIV_EN
    logic        sgn_q, sgn_d;      // current divide is signed and needs FIX
    logic        negq_q, negq_d;    // operand signs differ
    logic        negr_q, negr_d;    // dividend was negative
    logic        is_sdiv;
`endif

    logic [32:0] tmp;
    logic        ge;
    logic [31:0] diff;
    logic [63:0] step;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

    // One restoring step: shift in next dividend bit, subtract divisor when it fits
    always_comb begin
        tmp  = {rq_q[63:32], rq_q[31]};
        ge   = (tmp >= {1'b0, dvs_q});
        diff = tmp[31:0] - dvs_q;
        step = ge ? {diff, rq_q[30:0], 1'b1} : {tmp[31:0], rq_q[30:0], 1'b0};
    end

    // Operand magnitudes; the most negative value maps onto itself as unsigned
    always_comb begin
`ifdef HILO_SIGNED_DIV_EN
        is_sdiv = (op == OP_DIV);
        mag_a   = (is_sdiv && a[31]) ? (32'd0 - a) : a;
        mag_b   = (is_sdiv && b[31]) ? (32'd0 - b) : b;
`else
        mag_a   = a;
        mag_b   = b;
`endif
    end

    // Next-state and datapath updates for register writes and the divide FSM
    always_comb begin
        state_d = state_q;
        rq_d    = rq_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
`ifdef HILO_SIGNED_DIV_EN
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    case (op)
                        OP_MULWB: begin
                            hi_d = mul_result[63:32];
                            lo_d = mul_result[31:0];
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_DIVU, OP_DIV: begin
                            dz_d = (b == 32'd0);
`ifdef HILO_SIGNED_DIV_EN
                            sgn_d  = is_sdiv;
                            negq_d = is_sdiv && (a[31] ^ b[31]);
                            negr_d = is_sdiv && a[31];
`endif
                            if (b == 32'd0) begin
                                rq_d    = {a, 32'hFFFF_FFFF};
                                state_d = S_FIN;
                            end else begin
                                rq_d    = {32'd0, mag_a};
                                dvs_d   = mag_b;
                                cnt_d   = 5'd31;
                                state_d = S_ITER;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_ITER: begin
                rq_d = step;
                if (cnt_q == 5'd0) begin
`ifdef HILO_SIGNED_DIV_EN
                    state_d = sgn_q ? S_FIX : S_FIN;
`else
                    state_d = S_FIN;
`endif
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
`ifdef HILO_SIGNED_DIV_EN
            S_FIX: begin
                if (negq_q) rq_d[31:0]  = 32'd0 - rq_q[31:0];
                if (negr_q) rq_d[63:32] = 32'd0 - rq_q[63:32];
                state_d = S_FIN;
            end
`endif
            S_FIN: begin
                hi_d    = rq_q[63:32];
                lo_d    = rq_q[31:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // State and output registers; reset discards any divide in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rq_q    <= 64'd0;
            dvs_q   <= 32'd0;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
`ifdef HILO_SIGNED_DIV_EN
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rq_q    <= rq_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
`ifdef HILO_SIGNED_DIV_EN
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

endmodule

// File: tb/tb_hilo_div.sv
// tb/tb_hilo_div.sv - scoreboard testbench for hilo_div (honours HILO_SIGNED_DIV_EN)
module tb_hilo_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] mul_result;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    hilo_div dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .op         (op),
        .a          (a),
        .b          (b),
        .mul_result (mul_result),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } div_exp_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } reg_exp_t;

    div_exp_t dq[$];
    reg_exp_t wq[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the architectural rules
    task automatic model_div(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                             output logic [31:0] rhi, output logic [31:0] rlo, output int lat);
        longint sa, sb, q, r;
        if (ib == 32'd0) begin
            rlo = 32'hFFFF_FFFF;
            rhi = ia;
            lat = 0;
        end else begin
`ifdef HILO_SIGNED_DIV_EN
            if (o == 3'd5) begin
                sa  = longint'($signed(ia));
                sb  = longint'($signed(ib));
                q   = sa / sb;
                r   = sa % sb;
                rlo = q[31:0];
                rhi = r[31:0];
                lat = 33;
            end else begin
                rlo = ia / ib;
                rhi = ia % ib;
                lat = 32;
            end
`else
            sa  = 0; sb = 0; q = 0; r = 0;
            rlo = ia / ib;
            rhi = ia % ib;
            lat = 32;
            if (o == 3'd5) lat = 32;
`endif
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [63:0] im);
        div_exp_t    e;
        logic [31:0] rhi, rlo;
        int          lat;
        logic        is_div;
        is_div = (o == 3'd4) || (o == 3'd5);
        @(negedge clk);
        valid = 1'b1; op = o; a = ia; b = ib; mul_result = im;
        @(posedge clk);
        if (is_div) begin
            model_div(o, ia, ib, rhi, rlo, lat);
            e.hi  = rhi;
            e.lo  = rlo;
            e.dz  = (ib == 32'd0);
            e.due = cyc + 1 + lat;
            dq.push_back(e);
            m_hi = rhi;
            m_lo = rlo;
        end else begin
            case (o)
                3'd1: begin m_hi = im[63:32]; m_lo = im[31:0]; end
                3'd2: m_hi = ia;
                3'd3: m_lo = ia;
                default: ;
            endcase
            wq.push_back('{m_hi, m_lo});
        end
        @(negedge clk);
        valid = 1'b0;
        if (is_div) check("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Monitor: compares DUT-presented results against the scoreboard queues
    initial begin
        div_exp_t e;
        reg_exp_t w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    check("reg_hi", {32'd0, hi}, {32'd0, w.hi});
                    check("reg_lo", {32'd0, lo}, {32'd0, w.lo});
                end
                if (done) begin
                    if (dq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done=1 with no divide outstanding, required 0");
                    end else begin
                        e = dq.pop_front();
                        check("done_cycle", 64'(cyc), 64'(e.due));
                        check("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
                        @(negedge clk);
                        check("div_hi", {32'd0, hi}, {32'd0, e.hi});
                        check("div_lo", {32'd0, lo}, {32'd0, e.lo});
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        rst_n = 1'b0; valid = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; mul_result = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_div_zero", {63'd0, div_zero}, 64'd0);
        rst_n = 1'b1;

        issue(3'd1, 32'd0, 32'd0, 64'h0000_0001_FFFF_FFFE);
        issue(3'd2, 32'h0000_ABCD, 32'd0, 64'd0);

        // Reset in the middle of DIVU 100/7
        issue(3'd4, 32'd100, 32'd7, 64'd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        dq.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // DIVU 100/7 with a dropped MTLO while busy
        issue(3'd4, 32'd100, 32'd7, 64'd0);
        valid = 1'b1; op = 3'd3; a = 32'h0000_DEAD;
        @(negedge clk);
        valid = 1'b0;
        wait_idle();

        issue(3'd5, 32'hFFFF_FFF9, 32'd2, 64'd0);
        wait_idle();
        issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
        wait_idle();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
        wait_idle();
        issue(3'd4, 32'd5, 32'd0, 64'd0);
        wait_idle();
        issue(3'd4, 32'd9, 32'd3, 64'd0);
        wait_idle();
        issue(3'd5, 32'hFFFF_FFF0, 32'd0, 64'd0);
        wait_idle();
        issue(3'd6, 32'h1234_5678, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            ro  = 3'($urandom_range(1, 7));
            ra  = $urandom;
            sel = $urandom_range(0, 5);
            case (sel)
                0: rb = 32'd0;
                1, 2: rb = 32'($urandom_range(1, 20));
                3: rb = (($urandom & 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
                default: rb = $urandom;
            endcase
            if (ro == 3'd7) ro = 3'd5;
            issue(ro, ra, rb, {$urandom, $urandom});
            if (ro == 3'd4 || ro == 3'd5) wait_idle();
        end

        repeat (5) @(negedge clk);
        checks++;
        if (dq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d divide and %0d register expectations left, required 0",
                     dq.size(), wq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
